power_unit: RTL and testbench
=============================

POWER_UNIT -- requirements
Module: power_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk samples on the rising edge, and rst asserted high clears state immediately regardless of clk.
REQ-002 Port clk  input  1  system clock.
REQ-003 Port rst  input  1  asynchronous active-high reset.
REQ-004 Port in_valid  input  1  request strobe; one cycle per operation.
REQ-005 Port in_data_1  input  20  base x, unsigned Q10.10.
REQ-006 Port in_data_2  input  3  exponent n, unsigned integer 0..7.
REQ-007 Port out_valid  output  1  result strobe, one cycle per operation.
REQ-008 Port out_data  output  20  result x^n, unsigned Q10.10.
REQ-009 Port out_ovf  output  1  saturation flag; present only under POWER_UNIT_OVF_EN.

Function
REQ-010 The FSM SHALL have three states:
- ST_IDLE (reset state);
- ST_MUL;
- ST_OUTPUT.
REQ-011 In ST_IDLE with in_valid=1 at edge k, the block SHALL do the following at that edge:
- latch the base and the exponent;
- set acc to 20'h00400 if n=0, otherwise to the base;
- set cnt to 1;
- go to ST_OUTPUT if n<=1, otherwise to ST_MUL.
REQ-012 in_valid SHALL be ignored in ST_MUL and ST_OUTPUT; no queueing.
REQ-013 In ST_MUL each edge SHALL form a 40-bit product p=acc*base and then:
- if p[39:30]!=0, set acc to 20'hFFFFF, set the sticky ovf flag, and go to ST_OUTPUT immediately (early exit);
- otherwise set acc to p[29:10] (truncation, no rounding) and increment cnt.
REQ-014 ST_MUL SHALL exit to ST_OUTPUT on the edge where cnt+1==n, so exactly n-1 multiplies occur when there is no overflow.
REQ-015 In ST_OUTPUT the next edge SHALL drive out_valid=1 and out_data=acc (plus out_ovf=ovf when enabled), and SHALL return to ST_IDLE.
REQ-016 Latency: with no overflow, out_valid SHALL be high in the cycle after edge k+max(n,1).
REQ-017 out_valid SHALL be high for exactly one cycle per accepted request.
REQ-018 Whenever out_valid=0, out_data SHALL be 0 and out_ovf SHALL be 0.
REQ-019 An input in_valid on the same edge at which out_valid rises SHALL be ignored, because the FSM is in ST_OUTPUT at that edge; a new request is accepted from the following cycle onward.
REQ-020 For n=0 the result SHALL be 20'h00400 regardless of the base, including base=0.
REQ-021 A base of 0 with n>=1 SHALL yield 0 with ovf=0.

Reset
REQ-022 On rst the block SHALL set:
- state=ST_IDLE;
- acc=0, cnt=0, ovf=0;
- out_valid=0, out_data=0, out_ovf=0.
REQ-023 A reset during ST_MUL or ST_OUTPUT SHALL abort the operation with no out_valid pulse; after release the block SHALL accept a new request in ST_IDLE.

Configuration
REQ-024 The macro POWER_UNIT_OVF_EN SHALL control overflow reporting:
- defined: the out_ovf port and its output register exist;
- undefined: neither exists, and saturation plus early exit still behave identically.

Structure
REQ-025 A shared package SHALL hold:
- the state typedef (ST_IDLE, ST_MUL, ST_OUTPUT);
- FRAC_BITS=10;
- Q_ONE=20'h00400;
- Q_SAT=20'hFFFFF.
REQ-026 One combinational sub-module, q10_mul_sat, SHALL compute the 20x20 product, truncate it to Q10.10, and output the saturated value and an overflow bit; power_unit SHALL instantiate it once.

Verification
REQ-027 base=20'h00600 (1.5), n=2 -> out_data=20'h00900 (2.25), ovf=0, out_valid high in the cycle after edge k+2.
REQ-028 base=20'h12345, n=0 -> 20'h00400; base=20'h12345, n=1 -> 20'h12345; both with out_valid in the cycle after edge k+1.
REQ-029 base=20'h0A000 (40.0), n=3 -> 40^2 overflows on the first multiply -> out_data=20'hFFFFF, ovf=1, out_valid in the cycle after edge k+2 (early exit).
REQ-030 base=20'h00001, n=2 -> out_data=0 from truncation; base=20'h00800 (2.0), n=7 -> 20'h20000 (128.0) in the cycle after edge k+7.
REQ-031 Assert rst mid-way through an n=7 request -> no out_valid pulse; the next request, base=20'h00C00 (3.0), n=3, returns 20'h06C00 (27.0).
REQ-032 Pulse in_valid with base=20'h00800, n=2 while an n=7 request is busy -> the pulse is ignored; exactly one out_valid, carrying the n=7 result.

Source files
------------

// File: rtl/power_unit_pkg.sv
// Shared types and Q10.10 constants for the power_unit slice.
package power_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  localparam int unsigned FRAC_BITS = 10;
  localparam logic [19:0] Q_ONE     = 20'h00400;
  localparam logic [19:0] Q_SAT     = 20'hFFFFF;

endpackage

// File: rtl/q10_mul_sat.sv
// Combinational Q10.10 x Q10.10 multiply with truncation and saturation.
module q10_mul_sat
  import power_unit_pkg::*;
(
  input  logic [19:0] a,
  input  logic [19:0] b,
  output logic [19:0] res,
  output logic        ovf
);

  logic [39:0] prod;

  always_comb begin
    prod = 40'(a) * 40'(b);
    ovf  = |prod[39:30];
    res  = ovf ? Q_SAT : prod[FRAC_BITS +: 20];
  end

endmodule

// File: rtl/power_unit.sv
// Iterative x^n in unsigned Q10.10 (n = 0..7) with saturation and early exit.
// POWER_UNIT_OVF_EN adds the out_ovf port and its sticky overflow register.
module power_unit
  import power_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [19:0] in_data_1,
  input  logic [2:0]  in_data_2,
  output logic        out_valid,
  output logic [19:0] out_data
`ifdef POWER_UNIT_OVF_EN
  ,
  output logic        out_ovf
`endif
);

  state_t      state, state_next;
  logic [19:0] base, acc;
  logic [2:0]  n, cnt;
  logic [19:0] mul_res;
  logic        mul_ovf;
  logic        last_mul;
  logic        out_valid_d;
  logic [19:0] out_data_d;
`ifdef POWER_UNIT_OVF_EN
  logic        ovf;
  logic        out_ovf_d;
`endif

  q10_mul_sat u_mul (
    .a   (acc),
    .b   (base),
    .res (mul_res),
    .ovf (mul_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    last_mul   = ({1'b0, cnt} + 4'd1) == {1'b0, n};
    state_next = state;
    unique case (state)
      ST_IDLE:   if (in_valid) state_next = (in_data_2 <= 3'd1) ? ST_OUTPUT : ST_MUL;
      ST_MUL:    if (mul_ovf || last_mul) state_next = ST_OUTPUT;
      ST_OUTPUT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = (state == ST_OUTPUT);
    out_data_d  = out_valid_d ? acc : '0;
`ifdef POWER_UNIT_OVF_EN
    out_ovf_d   = out_valid_d ? ovf : 1'b0;
`endif
  end

  // mul_res is already saturated, so acc takes it unconditionally in ST_MUL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base      <= '0;
      n         <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef POWER_UNIT_OVF_EN
      ovf       <= 1'b0;
      out_ovf   <= 1'b0;
`endif
    end else begin
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
`ifdef POWER_UNIT_OVF_EN
      out_ovf   <= out_ovf_d;
`endif
      case (state)
        ST_IDLE: if (in_valid) begin
          base <= in_data_1;
          n    <= in_data_2;
          acc  <= (in_data_2 == 3'd0) ? Q_ONE : in_data_1;
          cnt  <= 3'd1;
`ifdef POWER_UNIT_OVF_EN
          ovf  <= 1'b0;
`endif
        end
        ST_MUL: begin
          acc <= mul_res;
          if (!mul_ovf) cnt <= cnt + 3'd1;
`ifdef POWER_UNIT_OVF_EN
          if (mul_ovf) ovf <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_power_unit.sv
// Scoreboard bench for power_unit: stimulus pushes expectations, a monitor checks outputs.
module tb_power_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [19:0] in_data_1;
  logic [2:0]  in_data_2;
  logic        out_valid;
  logic [19:0] out_data;
`ifdef POWER_UNIT_OVF_EN
  logic        out_ovf;
`endif

  power_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef POWER_UNIT_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  typedef struct {
    logic [19:0] data;
    logic        ovf;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: out_valid=1 out_data=%h at cycle %0d, required no pulse", out_data, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (out_data !== e.data) begin
            fails++;
            $display("FAIL %s data: got %h, required %h", e.name, out_data, e.data);
          end
          tests++;
          if (cyc != e.cyc) begin
            fails++;
            $display("FAIL %s latency: out_valid at cycle %0d, required %0d", e.name, cyc, e.cyc);
          end
`ifdef POWER_UNIT_OVF_EN
          tests++;
          if (out_ovf !== e.ovf) begin
            fails++;
            $display("FAIL %s ovf: got %b, required %b", e.name, out_ovf, e.ovf);
          end
`endif
        end
      end else begin
        tests++;
        if (out_data !== 20'h0) begin
          fails++;
          $display("FAIL idle_data: out_data=%h while out_valid=0, required 00000", out_data);
        end
`ifdef POWER_UNIT_OVF_EN
        tests++;
        if (out_ovf !== 1'b0) begin
          fails++;
          $display("FAIL idle_ovf: out_ovf=%b while out_valid=0, required 0", out_ovf);
        end
`endif
      end
    end
  end

  // Drive a request for 'hold' cycles; the expectation is tied to the first edge.
  task automatic issue(input logic [19:0] b, input logic [2:0] n, input logic [19:0] exp_data,
                       input logic exp_ovf, input int lat, input int hold, input bit track,
                       input string name);
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_1 = b;
    in_data_2 = n;
    if (track) begin
      e.data = exp_data;
      e.ovf  = exp_ovf;
      e.cyc  = cyc + 1 + lat;
      e.name = name;
      q.push_back(e);
    end
    repeat (hold) @(negedge clk);
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while (q.size() > 0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL %s timeout: %0d results outstanding after %0d cycles, required 0", name, q.size(), waited);
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_data !== 20'h0) begin
      fails++;
      $display("FAIL reset_outputs: out_valid=%b out_data=%h, required 0 00000", out_valid, out_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue(20'h00600, 3'd2, 20'h00900, 1'b0, 2, 1, 1'b1, "sq_1p5");     drain("sq_1p5");
    issue(20'h12345, 3'd0, 20'h00400, 1'b0, 1, 1, 1'b1, "n0");         drain("n0");
    issue(20'h12345, 3'd1, 20'h12345, 1'b0, 1, 1, 1'b1, "n1");         drain("n1");
    issue(20'h0A000, 3'd3, 20'hFFFFF, 1'b1, 2, 1, 1'b1, "ovf_early");  drain("ovf_early");
    issue(20'h00001, 3'd2, 20'h00000, 1'b0, 2, 1, 1'b1, "trunc");      drain("trunc");
    issue(20'h00800, 3'd7, 20'h20000, 1'b0, 7, 1, 1'b1, "two_pow7");   drain("two_pow7");
    issue(20'h00000, 3'd0, 20'h00400, 1'b0, 1, 1, 1'b1, "zero_n0");    drain("zero_n0");
    issue(20'h00000, 3'd3, 20'h00000, 1'b0, 3, 1, 1'b1, "zero_n3");    drain("zero_n3");
    issue(20'h07FFF, 3'd2, 20'hFFFC0, 1'b0, 2, 1, 1'b1, "sq_max_ok");  drain("sq_max_ok");
    issue(20'h08000, 3'd2, 20'hFFFFF, 1'b1, 2, 1, 1'b1, "sq_32_sat");  drain("sq_32_sat");

    // in_valid held over the edge where out_valid rises: second sample is ignored
    issue(20'h00C00, 3'd1, 20'h00C00, 1'b0, 1, 2, 1'b1, "hold_ovl");   drain("hold_ovl");

    // Back-to-back: new request on the cycle right after the result
    issue(20'h00600, 3'd1, 20'h00600, 1'b0, 1, 1, 1'b1, "b2b_a");
    issue(20'h00800, 3'd3, 20'h02000, 1'b0, 3, 1, 1'b1, "b2b_b");
    drain("b2b");

    // Pulse while busy is dropped
    issue(20'h00800, 3'd7, 20'h20000, 1'b0, 7, 1, 1'b1, "busy_n7");
    repeat (2) @(negedge clk);
    issue(20'h00800, 3'd2, 20'h00000, 1'b0, 2, 1, 1'b0, "ignored");
    drain("busy_n7");
    repeat (10) @(negedge clk);

    // Reset mid-operation aborts with no pulse
    issue(20'h00800, 3'd7, 20'h00000, 1'b0, 7, 1, 1'b0, "aborted");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 20'h0) begin
      fails++;
      $display("FAIL async_reset: out_valid=%b out_data=%h, required 0 00000", out_valid, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(20'h00C00, 3'd3, 20'h06C00, 1'b0, 3, 1, 1'b1, "after_rst");  drain("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
